jtag_dr_master: RTL and testbench
=================================

// Module: jtag_dr_master
// PURPOSE
// - Host-side JTAG initiator for one data-register scan. Drives TMS/TDI and samples TDO from a
//   TAP-controlled data register (DR) in the same TCK domain.
// - One request walks Run-Test/Idle -> Select-DR -> Capture-DR -> Shift-DR -> Exit1-DR ->
//   Update-DR -> Run-Test/Idle. It shifts DR_LEN bits in and returns the DR_LEN captured bits.
// - Used by the scan bench and by on-chip test sequencers to load and read test data registers.
// PARAMETERS
// - DR_LEN      5  target DR length in bits; >= 2.
// - RESET_TMS   5  TMS=1 cycles in the post-reset Test-Logic-Reset sequence; >= 5.
// PORTS
// - TCK      in   1       single clock; everything samples on posedge TCK.
// - rst      in   1       synchronous, active-high reset.
// - start    in   1       scan request; accepted only on an edge where ready=1.
// - wr_data  in   DR_LEN  data to load; latched at accept; MSB shifted first.
// - ready    out  1       idle in Run-Test/Idle, able to accept start.
// - done     out  1       one-cycle pulse at the end of a scan.
// - rd_data  out  DR_LEN  captured DR contents; first bit out of TDO is the MSB.
// - TMS      out  1       registered TAP mode select.
// - TDI      out  1       registered serial data to the target.
// - TDO      in   1       serial data from the target (DR MSB); sampled on posedge TCK.
// BEHAVIOUR
// - Reset values, while rst=1: TMS=1, TDI=0, ready=0, done=0, rd_data=0.
//   rst aborts any scan in progress on that edge, whatever the state.
// - Reset sequence, after rst drops:
//   - RESET_TMS-1 further cycles of TMS=1, for RESET_TMS TMS=1 cycles total including the
//     first cycle after rst falls.
//   - Then one cycle of TMS=0 (Test-Logic-Reset -> Run-Test/Idle).
//   - Then ready=1 with TMS=0 held.
// - FSM states: RST_SEQ, IDLE, SEL, CAP, SHIFT, EXIT1, UPD, DONE.
//   The FSM mirrors the target TAP state using the TMS it registers.
// - Accept: edge E0 with start=1 and ready=1 latches wr_data and sets ready=0.
//   start with ready=0 is ignored; there is no queueing.
// - Cycle k after E0 drives:
//   - k=1: TMS=1 (Select-DR).
//   - k=2: TMS=0 (Capture-DR).
//   - k=3: TMS=0 (Shift-DR).
//   - k=4..3+DR_LEN: TDI = wr_data[DR_LEN-1 .. 0], one bit per cycle. TMS=0, except TMS=1 in
//     k=3+DR_LEN (exit to Exit1-DR). At each of these edges TDO is sampled:
//     rd_shift <= {rd_shift[DR_LEN-2:0], TDO}.
//   - k=4+DR_LEN: TMS=1 (Update-DR).
//   - k=5+DR_LEN: TMS=0 (back to Run-Test/Idle). The target updates on this edge.
//   - k=6+DR_LEN: done=1 for exactly one cycle, ready=1, rd_data <= rd_shift.
//   - Latency from accept to done = DR_LEN+6 cycles.
// - TDI outside shift cycles = 0.
// - rd_data holds its value until the next done; it is not updated mid-scan.
// - start in the done cycle is accepted, giving back-to-back scans with no extra idle cycle.
// - Shift counter: $clog2(DR_LEN)+1 bits, counting DR_LEN-1 down to 0.
//   The TMS=1 exit is driven when the counter reaches 0.
// - TDO X/Z: no special handling; it is sampled as-is.
// CONFIGURATION
// - Macro JTAG_CAPTURE_CHECK_EN. When defined:
//   - Adds input cap_exp[DR_LEN-1:0] and output cap_err (1 bit, reset value 0).
//   - cap_exp is latched at accept.
//   - In the done cycle, cap_err <= (rd_shift != latched cap_exp).
//   - cap_err holds until the next done or rst.
// - When undefined: neither port exists and there is no compare logic.
// TESTING
// - Reset: rst=1 for 2 cycles, then 0 -> TMS=1 for 5 cycles, TMS=0 for 1 cycle, ready=1 in
//   the 7th cycle after rst falls; done=0 and rd_data=0 throughout.
// - Single scan against the 5-bit TAP+DR model (capture all-ones), wr_data=5'b10110 ->
//   - TMS sequence 1,0,0,0,0,0,0,1,1,0.
//   - TDI=1,0,1,1,0 in cycles k=4..8.
//   - Target DR_OUT=5'b10110 after the k=10 edge.
//   - rd_data=5'b11111 and done=1 at k=11.
// - Back-to-back: start=1 held with wr_data=5'b00001 in the done cycle of the previous scan ->
//   - Accepted immediately.
//   - Second done exactly 11 cycles later.
//   - DR_OUT=5'b00001, rd_data=5'b11111.
// - Ignore/latch:
//   - Pulse start at k=5 -> no effect, done count stays 1.
//   - Change wr_data at k=2 -> the shifted bits still equal the value latched at E0.
// - Abort: rst=1 at k=6 ->
//   - TMS=1 from the next cycle, done never pulses, DR_OUT unchanged.
//   - Full reset sequence runs, then ready=1.
// - With JTAG_CAPTURE_CHECK_EN, TDO forced 0:
//   - cap_exp=5'b11111 -> rd_data=5'b00000 and cap_err=1 at done.
//   - Rerun with the model and cap_exp=5'b11111 -> cap_err=0.

Source files
------------

// File: rtl/jtag_dr_master.sv
// jtag_dr_master: host-side JTAG initiator performing one data-register scan per request.
// Walks Run-Test/Idle -> Select-DR -> Capture-DR -> Shift-DR -> Exit1-DR -> Update-DR ->
// Run-Test/Idle. It shifts wr_data in MSB first and returns the DR_LEN captured bits.
// Optional feature: define JTAG_CAPTURE_CHECK_EN to add cap_exp/cap_err, which compare the
// captured bits with an expected pattern latched at accept.
module jtag_dr_master #(
    parameter int DR_LEN    = 5,
    parameter int RESET_TMS = 5
) (
    input  logic              TCK,
    input  logic              rst,
    input  logic              start,
    input  logic [DR_LEN-1:0] wr_data,
`ifdef JTAG_CAPTURE_CHECK_EN
    input  logic [DR_LEN-1:0] cap_exp,
    output logic              cap_err,
`endif
    output logic              ready,
    output logic              done,
    output logic [DR_LEN-1:0] rd_data,
    output logic              TMS,
    output logic              TDI,
    input  logic              TDO
);

    localparam int CNT_W  = $clog2(DR_LEN) + 1;
    localparam int RCNT_W = $clog2(RESET_TMS + 1);

    // Each state names the TAP state the target will be in once the TMS driven during
    // that cycle has been sampled; DONE is the cycle whose TMS=0 returns it to Idle.
    typedef enum logic [2:0] {
        RST_SEQ,
        IDLE,
        SEL,
        CAP,
        SHIFT,
        EXIT1,
        UPD,
        DONE
    } state_t;

    state_t              state;
    logic [RCNT_W-1:0]   rcnt;
    logic [CNT_W-1:0]    cnt;
    logic [DR_LEN-1:0]   wr_q;
    logic [DR_LEN-1:0]   rd_shift;
    logic                accept;
    logic                sample_tdo;

    // A request is taken only while idle and advertising ready.
    assign accept = start && ready && (state == IDLE);

    // TDO is valid from the first cycle after Capture-DR through the Exit1 transition; the
    // first SHIFT cycle still has the target in Capture-DR, so it is skipped.
    assign sample_tdo = ((state == SHIFT) && (cnt != CNT_W'(DR_LEN - 1))) || (state == EXIT1);

`ifdef JTAG_CAPTURE_CHECK_EN
    logic [DR_LEN-1:0]   cap_exp_q;

    // Expected capture pattern is held for the whole scan.
    always_ff @(posedge TCK) begin
        if (accept) begin
            cap_exp_q <= cap_exp;
        end
    end
`endif

    // Data path: latch write data at accept, shift it out MSB first, collect TDO.
    always_ff @(posedge TCK) begin
        if (accept) begin
            wr_q <= wr_data;
        end else if (state == SHIFT) begin
            wr_q <= {wr_q[DR_LEN-2:0], 1'b0};
        end
        if (sample_tdo) begin
            rd_shift <= {rd_shift[DR_LEN-2:0], TDO};
        end
    end

    // Control FSM: drives registered TMS/TDI/ready/done and publishes the result.
    always_ff @(posedge TCK) begin
        if (rst) begin
            state   <= RST_SEQ;
            rcnt    <= '0;
            cnt     <= '0;
            TMS     <= 1'b1;
            TDI     <= 1'b0;
            ready   <= 1'b0;
            done    <= 1'b0;
            rd_data <= '0;
`ifdef JTAG_CAPTURE_CHECK_EN
            cap_err <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                RST_SEQ: begin
                    // TMS=1 until RESET_TMS cycles are out, then one TMS=0 into Idle.
                    if (rcnt == RCNT_W'(RESET_TMS)) begin
                        state <= IDLE;
                        ready <= 1'b1;
                        TMS   <= 1'b0;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                        TMS  <= (rcnt != RCNT_W'(RESET_TMS - 1));
                    end
                end
                IDLE: begin
                    TMS <= 1'b0;
                    if (start && ready) begin
                        ready <= 1'b0;
                        TMS   <= 1'b1;
                        state <= SEL;
                    end
                end
                SEL: begin
                    TMS   <= 1'b0;
                    state <= CAP;
                end
                CAP: begin
                    TMS   <= 1'b0;
                    cnt   <= CNT_W'(DR_LEN - 1);
                    state <= SHIFT;
                end
                SHIFT: begin
                    TDI <= wr_q[DR_LEN-1];
                    // Last data bit goes out together with TMS=1 to leave Shift-DR.
                    if (cnt == '0) begin
                        TMS   <= 1'b1;
                        state <= EXIT1;
                    end else begin
                        TMS <= 1'b0;
                        cnt <= cnt - 1'b1;
                    end
                end
                EXIT1: begin
                    TDI   <= 1'b0;
                    TMS   <= 1'b1;
                    state <= UPD;
                end
                UPD: begin
                    TMS   <= 1'b0;
                    state <= DONE;
                end
                DONE: begin
                    TMS     <= 1'b0;
                    done    <= 1'b1;
                    ready   <= 1'b1;
                    rd_data <= rd_shift;
`ifdef JTAG_CAPTURE_CHECK_EN
                    cap_err <= (rd_shift != cap_exp_q);
`endif
                    state   <= IDLE;
                end
                default: begin
                    state <= RST_SEQ;
                    rcnt  <= '0;
                    TMS   <= 1'b1;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_dr_master.sv
// tb_jtag_dr_master: scoreboard bench for jtag_dr_master against a behavioural 16-state TAP
// with a DR_LEN-bit data register (capture value all-ones). The bench rst doubles as the
// target's TRST, so a reset puts the TAP straight into Test-Logic-Reset without an update.
module tb_jtag_dr_master;

    localparam int N  = 5;
    localparam int RT = 5;

    logic         TCK = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] wr_data;
    logic         ready;
    logic         done;
    logic [N-1:0] rd_data;
    logic         TMS;
    logic         TDI;
    logic         TDO;
`ifdef JTAG_CAPTURE_CHECK_EN
    logic [N-1:0] cap_exp;
    logic         cap_err;
`endif

    jtag_dr_master #(.DR_LEN(N), .RESET_TMS(RT)) dut (
        .TCK     (TCK),
        .rst     (rst),
        .start   (start),
        .wr_data (wr_data),
`ifdef JTAG_CAPTURE_CHECK_EN
        .cap_exp (cap_exp),
        .cap_err (cap_err),
`endif
        .ready   (ready),
        .done    (done),
        .rd_data (rd_data),
        .TMS     (TMS),
        .TDI     (TDI),
        .TDO     (TDO)
    );

    always #5 TCK = ~TCK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int n_done = 0;
    int n_exp_done = 0;

    always @(posedge TCK) cyc <= cyc + 1;

    // ---------------- target TAP + data register ----------------
    typedef enum int {
        T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PADR, T_EX2DR, T_UPDR,
        T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PAIR, T_EX2IR, T_UPIR
    } tap_t;

    tap_t         tap    = T_TLR;
    logic [N-1:0] dr_sh  = '0;
    logic [N-1:0] dr_out = '0;
    logic         tdo_zero = 1'b0;

    function automatic tap_t next_tap(input tap_t s, input logic m);
        case (s)
            T_TLR:   return m ? T_TLR   : T_RTI;
            T_RTI:   return m ? T_SELDR : T_RTI;
            T_SELDR: return m ? T_SELIR : T_CAPDR;
            T_CAPDR: return m ? T_EX1DR : T_SHDR;
            T_SHDR:  return m ? T_EX1DR : T_SHDR;
            T_EX1DR: return m ? T_UPDR  : T_PADR;
            T_PADR:  return m ? T_EX2DR : T_PADR;
            T_EX2DR: return m ? T_UPDR  : T_SHDR;
            T_UPDR:  return m ? T_SELDR : T_RTI;
            T_SELIR: return m ? T_TLR   : T_CAPIR;
            T_CAPIR: return m ? T_EX1IR : T_SHIR;
            T_SHIR:  return m ? T_EX1IR : T_SHIR;
            T_EX1IR: return m ? T_UPIR  : T_PAIR;
            T_PAIR:  return m ? T_EX2IR : T_PAIR;
            T_EX2IR: return m ? T_UPIR  : T_SHIR;
            default: return m ? T_SELDR : T_RTI;
        endcase
    endfunction

    always @(posedge TCK) begin
        if (rst) begin
            tap <= T_TLR;
        end else begin
            case (tap)
                T_CAPDR: dr_sh  <= '1;
                T_SHDR:  dr_sh  <= {dr_sh[N-2:0], TDI};
                T_UPDR:  dr_out <= dr_sh;
                default: ;
            endcase
            tap <= next_tap(tap, TMS);
        end
    end

    assign TDO = tdo_zero ? 1'b0 : dr_sh[N-1];

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        logic [N-1:0] wr;
        logic [N-1:0] rd;
        int           acc;
        logic [N-1:0] cexp;
    } exp_t;

    exp_t sb[$];

    // Expected pins in cycle k after accept (k=1 is the cycle following the accept edge).
    function automatic logic exp_tms(input int k);
        return (k == 1) || (k == N + 3) || (k == N + 4);
    endfunction

    function automatic logic exp_tdi(input int k, input logic [N-1:0] w);
        if (k >= 4 && k <= N + 3) return w[N + 3 - k];
        return 1'b0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    int   mon_k;
    exp_t mon_e;

    always @(negedge TCK) begin
        if (rst === 1'b0) begin
            if (sb.size() > 0) begin
                mon_k = cyc - sb[0].acc;
                if (mon_k >= 1 && mon_k <= N + 5)
                    chk("scan_trace", 32'({ready, done, TMS, TDI}),
                        32'({2'b00, exp_tms(mon_k), exp_tdi(mon_k, sb[0].wr)}));
            end
            if (done === 1'b1) begin
                n_done++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'(0));
                end else begin
                    mon_e = sb.pop_front();
                    chk("done_latency", 32'(cyc - mon_e.acc), 32'(N + 6));
                    chk("rd_data", 32'(rd_data), 32'(mon_e.rd));
                    chk("dr_out", 32'(dr_out), 32'(mon_e.wr));
                    chk("ready_at_done", 32'(ready), 32'(1));
                    chk("tap_idle_at_done", 32'(tap == T_RTI), 32'(1));
`ifdef JTAG_CAPTURE_CHECK_EN
                    chk("cap_err", 32'(cap_err), 32'(mon_e.rd != mon_e.cexp));
`endif
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_cexp(input logic [N-1:0] v);
`ifdef JTAG_CAPTURE_CHECK_EN
        cap_exp = v;
`else
        if (v === 'x) $display("note: cap_exp unknown");
`endif
    endtask

    task automatic issue(input logic [N-1:0] wr, input logic [N-1:0] cexp, output int acc);
        int t;
        t = 0;
        acc = cyc;
        while (ready !== 1'b1 && t < 200) begin
            start = 1'b0;
            @(negedge TCK);
            t++;
        end
        if (ready !== 1'b1) begin
            chk("ready_timeout", 32'(ready), 32'(1));
            return;
        end
        start   = 1'b1;
        wr_data = wr;
        drive_cexp(cexp);
        acc = cyc;
        sb.push_back('{wr, tdo_zero ? {N{1'b0}} : {N{1'b1}}, cyc, cexp});
        n_exp_done++;
        @(negedge TCK);
        start   = 1'b0;
        wr_data = N'($urandom);
        drive_cexp(N'($urandom));
    endtask

    // Waits for done while scribbling on start/wr_data; the scan must ignore both.
    task automatic wait_done();
        int t;
        t = 0;
        while (done !== 1'b1 && t < 60) begin
            start   = 1'($urandom_range(0, 1));
            wr_data = N'($urandom);
            drive_cexp(N'($urandom));
            @(negedge TCK);
            t++;
        end
        start = 1'b0;
        if (done !== 1'b1) chk("done_timeout", 32'(done), 32'(1));
    endtask

    task automatic do_reset(input int hold);
        rst   = 1'b1;
        start = 1'b0;
        sb.delete();
        for (int i = 0; i < hold; i++) begin
            @(negedge TCK);
            chk("rst_state", 32'({TMS, TDI, ready, done, rd_data}),
                32'({1'b1, 1'b0, 1'b0, 1'b0, {N{1'b0}}}));
        end
        rst = 1'b0;
        for (int i = 1; i <= RT + 2; i++) begin
            chk("rst_seq", 32'({TMS, TDI, ready, done, rd_data}),
                32'({(i <= RT), 1'b0, (i == RT + 2), 1'b0, {N{1'b0}}}));
            if (i < RT + 2) @(negedge TCK);
        end
        chk("rst_tap_idle", 32'(tap == T_RTI), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int           acc;
        int           gap;
        logic [N-1:0] w;
        logic [N-1:0] dr_before;

        rst     = 1'b1;
        start   = 1'b0;
        wr_data = '0;
        drive_cexp('0);
        do_reset(2);

        // directed single scan, then back-to-back in the done cycle
        issue(5'b10110, 5'b11111, acc);
        wait_done();
        issue(5'b00001, 5'b11111, acc);
        wait_done();

        // TDO held low: captured bits all zero, capture check flags it
        start = 1'b0;
        @(negedge TCK);
        tdo_zero = 1'b1;
        issue(5'b01011, 5'b11111, acc);
        wait_done();
        start = 1'b0;
        @(negedge TCK);
        tdo_zero = 1'b0;
        issue(5'b11010, 5'b11111, acc);
        wait_done();

        // abort mid-shift at k=6
        issue(5'b01101, 5'b11111, acc);
        for (int t = 0; t < 20 && (cyc - acc) < 6; t++) begin
            start = 1'($urandom_range(0, 1));
            @(negedge TCK);
        end
        chk("abort_point", 32'(cyc - acc), 32'(6));
        dr_before = dr_out;
        n_exp_done--;
        do_reset(2);
        chk("abort_dr_out", 32'(dr_out), 32'(dr_before));

        // randomized scans with random gaps (gap 0 = back-to-back)
        for (int i = 0; i < 30; i++) begin
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                start   = 1'b0;
                wr_data = N'($urandom);
                @(negedge TCK);
            end
            if (gap > 0) tdo_zero = 1'($urandom_range(0, 1));
            w = N'($urandom);
            if ($urandom_range(0, 1) == 1)
                issue(w, tdo_zero ? {N{1'b0}} : {N{1'b1}}, acc);
            else
                issue(w, N'($urandom), acc);
            wait_done();
        end

        start = 1'b0;
        repeat (3) @(negedge TCK);
        chk("done_count", 32'(n_done), 32'(n_exp_done));
        chk("scoreboard_empty", 32'(sb.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
